// File: rtl/counter_binary_ranged_if.sv
// counter_binary_ranged_if: control and status bundle for counter_binary_ranged.
// The master drives the controls, step and bounds.
// The slave (the counter) drives count, at_low, at_high and bound_event.
interface counter_binary_ranged_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  clear;
  logic                  run;
  logic                  up_down;
  logic                  load;
  logic [WORD_WIDTH-1:0] load_count;
  logic [WORD_WIDTH-1:0] step;
  logic [WORD_WIDTH-1:0] limit_low;
  logic [WORD_WIDTH-1:0] limit_high;
  logic                  saturate;
  logic [WORD_WIDTH-1:0] count;
  logic                  at_low;
  logic                  at_high;
  logic                  bound_event;

  modport master (
    output clear, run, up_down, load, load_count, step,
           limit_low, limit_high, saturate,
    input  count, at_low, at_high, bound_event
  );

  modport slave (
    input  clear, run, up_down, load, load_count, step,
           limit_low, limit_high, saturate,
    output count, at_low, at_high, bound_event
  );
endinterface

// File: rtl/counter_binary_ranged.sv
// counter_binary_ranged: up/down counter with a run-time step and run-time
// inclusive bounds. It either wraps (reloads the opposite bound) or saturates
// at those bounds, and raises a registered boundary-event pulse.
// Optional build macro COUNTER_BINARY_RANGED_SATURATE_EN:
// - defined: the saturate input selects wrap or saturate on each cycle.
// - undefined: the saturate input is ignored and the counter always wraps.
module counter_binary_ranged #(
  parameter int WORD_WIDTH    = 8,
  parameter int INITIAL_COUNT = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  counter_binary_ranged_if.slave  bus
);

  localparam logic [WORD_WIDTH-1:0] INIT_VALUE = WORD_WIDTH'(INITIAL_COUNT);

  logic [WORD_WIDTH-1:0] count_q;
  logic [WORD_WIDTH-1:0] count_d;
  logic                  bound_event_q;
  logic                  bound_event_d;

  // Everything is one bit wider than the count so a carry or borrow stays
  // visible. It must never wrap silently through 2^WORD_WIDTH.
  logic [WORD_WIDTH:0]   sum_s;
  logic [WORD_WIDTH:0]   diff_s;
  logic                  overflow_s;
  logic                  underflow_s;
  logic                  hit_s;
  logic                  sat_s;

  // Extended add/sub and boundary detection for the current direction.
  always_comb begin
    sum_s       = {1'b0, count_q} + {1'b0, bus.step};
    diff_s      = {1'b0, count_q} - {1'b0, bus.step};
    // A zero step never produces an event, even when count is out of range.
    overflow_s  = (bus.step != {WORD_WIDTH{1'b0}}) &&
                  (sum_s > {1'b0, bus.limit_high});
    // diff_s[WORD_WIDTH] is the borrow, so it is set when count < step.
    underflow_s = (bus.step != {WORD_WIDTH{1'b0}}) &&
                  (diff_s[WORD_WIDTH] || (diff_s[WORD_WIDTH-1:0] < bus.limit_low));
    if (bus.up_down) begin
      hit_s = underflow_s;
    end else begin
      hit_s = overflow_s;
    end
  end

  // Wrap/saturate mode select; without the macro the mode is fixed to wrap.
  always_comb begin
`ifdef COUNTER_BINARY_RANGED_SATURATE_EN
    sat_s = bus.saturate;
`else
    sat_s = 1'b0;
`endif
  end

  // Next-state selection in priority order: clear, load, run, hold.
  always_comb begin
    count_d       = count_q;
    bound_event_d = 1'b0;
    if (bus.clear) begin
      count_d = INIT_VALUE;
    end else if (bus.load) begin
      count_d = bus.load_count;
    end else if (bus.run) begin
      if (hit_s) begin
        bound_event_d = 1'b1;
        // Overflow reloads low (wrap) or pins high (saturate); underflow mirrors it.
        case ({bus.up_down, sat_s})
          2'b00:   count_d = bus.limit_low;
          2'b01:   count_d = bus.limit_high;
          2'b10:   count_d = bus.limit_high;
          2'b11:   count_d = bus.limit_low;
          default: count_d = count_q;
        endcase
      end else if (bus.up_down) begin
        count_d = diff_s[WORD_WIDTH-1:0];
      end else begin
        count_d = sum_s[WORD_WIDTH-1:0];
      end
    end else begin
      count_d = count_q;
    end
  end

  // State register: asynchronous reset to the initial count, event cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q       <= INIT_VALUE;
      bound_event_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      bound_event_q <= bound_event_d;
    end
  end

  // Outputs: registered count and event, combinational bound flags.
  always_comb begin
    bus.count       = count_q;
    bus.bound_event = bound_event_q;
    bus.at_low      = (count_q == bus.limit_low);
    bus.at_high     = (count_q == bus.limit_high);
  end

endmodule

// File: tb/tb_counter_binary_ranged.sv
// tb_counter_binary_ranged: directed test of counter_binary_ranged, with
// WORD_WIDTH=8 and INITIAL_COUNT=5. An integer model of the counting rules
// is compared with the DUT on every falling clock edge. Hand-computed
// literals pin both the DUT and that model.
module tb_counter_binary_ranged;

  localparam int W    = 8;
  localparam int INIT = 5;

  logic clock;
  logic reset_n;

  counter_binary_ranged_if #(.WORD_WIDTH(W)) bus ();

  counter_binary_ranged #(.WORD_WIDTH(W), .INITIAL_COUNT(INIT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int model_count;
  bit model_ev;
  bit cmp_en = 1'b0;

`ifdef COUNTER_BINARY_RANGED_SATURATE_EN
  localparam bit SAT_BUILT = 1'b1;
`else
  localparam bit SAT_BUILT = 1'b0;
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arithmetic, so no bit width can wrap.
  always @(posedge clock or negedge reset_n) begin
    int nxt;
    int lo;
    int hi;
    int st;
    bit sat;
    lo  = int'(bus.limit_low);
    hi  = int'(bus.limit_high);
    st  = int'(bus.step);
    sat = SAT_BUILT && bus.saturate;
    if (!reset_n) begin
      model_count = INIT;
      model_ev    = 1'b0;
    end else if (bus.clear) begin
      model_count = INIT;
      model_ev    = 1'b0;
    end else if (bus.load) begin
      model_count = int'(bus.load_count);
      model_ev    = 1'b0;
    end else if (bus.run && st != 0) begin
      if (!bus.up_down) begin
        nxt = model_count + st;
        if (nxt > hi) begin
          model_count = sat ? hi : lo;
          model_ev    = 1'b1;
        end else begin
          model_count = nxt;
          model_ev    = 1'b0;
        end
      end else begin
        nxt = model_count - st;
        if (nxt < lo) begin
          model_count = sat ? lo : hi;
          model_ev    = 1'b1;
        end else begin
          model_count = nxt;
          model_ev    = 1'b0;
        end
      end
    end else begin
      model_ev = 1'b0;
    end
  end

  // Every falling edge: compare all DUT outputs with the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cmp_count", int'(bus.count), model_count);
      check("cmp_event", int'(bus.bound_event), int'(model_ev));
      check("cmp_at_low", int'(bus.at_low), int'(model_count == int'(bus.limit_low)));
      check("cmp_at_high", int'(bus.at_high), int'(model_count == int'(bus.limit_high)));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic expect_state(input string name, input int cnt, input int ev);
    check({name, "_count"}, int'(bus.count), cnt);
    check({name, "_event"}, int'(bus.bound_event), ev);
    check({name, "_model"}, model_count, cnt);
  endtask

  task automatic set_bounds(input int lo, input int hi, input int st);
    bus.limit_low  = W'(lo);
    bus.limit_high = W'(hi);
    bus.step       = W'(st);
  endtask

  task automatic do_load(input int v);
    bus.run        = 1'b0;
    bus.load       = 1'b1;
    bus.load_count = W'(v);
    tick();
    bus.load       = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.clear      = 1'b0;
    bus.run        = 1'b0;
    bus.up_down    = 1'b0;
    bus.load       = 1'b0;
    bus.load_count = '0;
    bus.saturate   = 1'b0;
    set_bounds(2, 9, 1);
    tick();
    tick();
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    expect_state("reset", 5, 0);

    // Up-wrap, low=2 high=9 step=3: 2, 5, 8, 2 (event), 5.
    set_bounds(2, 9, 3);
    do_load(2);
    expect_state("upwrap_load", 2, 0);
    check("upwrap_at_low0", int'(bus.at_low), 1);
    bus.run = 1'b1;
    bus.up_down = 1'b0;
    tick(); expect_state("upwrap_1", 5, 0);
    tick(); expect_state("upwrap_2", 8, 0);
    tick(); expect_state("upwrap_3", 2, 1);
    check("upwrap_at_low3", int'(bus.at_low), 1);
    tick(); expect_state("upwrap_4", 5, 0);

    // A clear at count 9 returns the count to INITIAL_COUNT.
    do_load(9);
    expect_state("clr_pre", 9, 0);
    bus.clear = 1'b1;
    bus.load  = 1'b1;
    tick(); expect_state("clear", 5, 0);
    bus.clear = 1'b0;
    bus.load  = 1'b0;

    // Down with saturate=1, low=2 high=9 step=4: 9, 5, 2, 2 (saturate) or 9, 5, 9, 5 (wrap).
    set_bounds(2, 9, 4);
    do_load(9);
    expect_state("dsat_load", 9, 0);
    bus.saturate = 1'b1;
    bus.up_down  = 1'b1;
    bus.run      = 1'b1;
    tick(); expect_state("dsat_1", 5, 0);
    tick(); expect_state("dsat_2", SAT_BUILT ? 2 : 9, 1);
    tick(); expect_state("dsat_3", SAT_BUILT ? 2 : 5, SAT_BUILT ? 1 : 0);

    // Up with saturate held at the top: the event stays high while saturated.
    set_bounds(2, 9, 3);
    do_load(8);
    bus.up_down = 1'b0;
    bus.run     = 1'b1;
    tick(); expect_state("usat_1", SAT_BUILT ? 9 : 2, 1);
    tick(); expect_state("usat_2", SAT_BUILT ? 9 : 5, SAT_BUILT ? 1 : 0);
    bus.saturate = 1'b0;

    // Full-width carry: 100 + 200 with high=255 wraps to low (0), not to 44.
    set_bounds(0, 255, 200);
    do_load(100);
    bus.run = 1'b1;
    tick(); expect_state("carry", 0, 1);

    // Load beats run; the out-of-range count then overflows and wraps to low.
    set_bounds(2, 9, 1);
    bus.load       = 1'b1;
    bus.load_count = W'(50);
    bus.run        = 1'b1;
    tick(); expect_state("load_prio", 50, 0);
    bus.load = 1'b0;
    tick(); expect_state("oor_wrap", 2, 1);

    // A zero step holds the count in both directions with no event.
    set_bounds(2, 9, 0);
    do_load(7);
    bus.run = 1'b1;
    bus.up_down = 1'b0;
    tick(); expect_state("step0_up", 7, 0);
    bus.up_down = 1'b1;
    tick(); expect_state("step0_dn", 7, 0);

    // Asynchronous reset mid-count, taken while the event is high.
    set_bounds(2, 9, 3);
    do_load(8);
    bus.up_down = 1'b0;
    bus.run = 1'b1;
    tick(); expect_state("prerst", 2, 1);
    bus.run = 1'b0;
    #1 reset_n = 1'b0;
    #1 expect_state("async_rst", 5, 0);
    @(negedge clock);
    reset_n = 1'b1;
    bus.run = 1'b1;
    tick(); expect_state("post_rst", 8, 0);
    bus.run = 1'b0;
    tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_binary_ranged.md
# counter_binary_ranged

Up/down binary counter with a run-time step and run-time lower/upper bounds, wrapping or saturating at those bounds, with a registered boundary-event pulse. It replaces fixed-increment, full-range counters wherever a loop index, modulo address or credit count has limits set by software or by the surrounding datapath. It sits between control FSMs and address/credit datapaths.

## Interface
- WORD_WIDTH, 8, width of count, step and bounds (≥2)
- INITIAL_COUNT, 0, value of `count` after reset or `clear`
- clock  input  1  sole clock; all state updates on the rising edge
- reset_n  input  1  asynchronous active-low reset: assertion forces reset values immediately; release is synchronised externally
- clear  input  1  synchronous reset to INITIAL_COUNT, also clears `bound_event`
- run  input  1  advance count by `step` this cycle
- up_down  input  1  0 counts up, 1 counts down
- load  input  1  load `load_count`; overrides `run`, works when `run`=0
- load_count  input  WORD_WIDTH  value to load, unchecked against bounds
- step  input  WORD_WIDTH  unsigned amount added or subtracted per `run` cycle
- limit_low  input  WORD_WIDTH  lower bound, inclusive; must be ≤ `limit_high`
- limit_high  input  WORD_WIDTH  upper bound, inclusive
- saturate  input  1  0 wraps at bounds, 1 saturates; see Configuration
- count  output  WORD_WIDTH  registered count
- at_low  output  1  combinational, `count == limit_low`
- at_high  output  1  combinational, `count == limit_high`
- bound_event  output  1  registered, high the cycle after an update that hit overflow or underflow

## Operation
- Priority per edge: reset_n, then clear, then load, then run, then hold.
- Arithmetic is done on WORD_WIDTH+1 bits, so there is no silent 2^WORD_WIDTH wrap.
- Up overflow: `count + step > limit_high`, unsigned with carry.
- Down underflow: `count < step` OR `count - step < limit_low`.
- No overflow/underflow: next = count ± step.
- Wrap mode (reload semantics, no remainder carried):
  - overflow, next = `limit_low`
  - underflow, next = `limit_high`
- Saturate mode:
  - overflow, next = `limit_high`
  - underflow, next = `limit_low`
- Out-of-range count (after a load or a bound change) is resolved by the same rules on the next `run`. For example, count > high counting up counts as overflow.
- `step` = 0: count holds and no event is raised.
- `bound_event` is set to 1 on a `run` update (without `load` or `clear`) that overflowed or underflowed. Otherwise it is set to 0. Load, clear and hold cycles write 0.
- When held saturated with `run`=1, step≠0 and the same direction, `bound_event` stays high every cycle.
- `limit_low` > `limit_high` is illegal; count behaviour is unspecified, but no X may propagate.

## Timing
- Reset values: `count` = INITIAL_COUNT, `bound_event` = 0. `at_low` and `at_high` follow from those.
- Latency:
  - `count` and `bound_event` change one cycle after the qualifying edge.
  - `at_low` and `at_high` change in the same cycle as `count` and `limit_*`.
- `reset_n` asserted mid-count takes effect without a clock edge. The first edge after release applies normal priority.
- `load` and `run` together: the load wins and `bound_event` = 0.
- `clear` and `load` together: the clear wins.
- Bounds and step are sampled at the edge. Changing them takes effect on the next update; no pipelining.
- Critical path: one WORD_WIDTH+1 add/sub, then compares, then a 4:1 mux into the register.

## Configuration
- `COUNTER_BINARY_RANGED_SATURATE_EN`
- Defined: the `saturate` port selects wrap or saturate per cycle as above.
- Undefined: the `saturate` port is present but ignored, the saturate logic is not built, and the counter always wraps.
- Bench runs both builds; saturate tests expect wrap results when the macro is undefined.

## Test plan
- Reset and clear:
  - INITIAL_COUNT=5, reset_n low mid-count → `count`=5 and `bound_event`=0 immediately, without a clock edge.
  - `clear` pulse at count 9 → 5 next cycle.
- Up-wrap:
  - low=2, high=9, step=3, load 2, run up → 2, 5, 8, 2.
  - `bound_event`=1 only in the cycle `count` shows the wrapped 2.
  - `at_low`=1 at each 2.
- Down-saturate (macro defined):
  - low=2, high=9, step=4, load 9, saturate=1, run down → 9, 5, 2, 2.
  - `bound_event` is 1 on both 2s.
  - Same stimulus with the macro undefined → 9, 5, 9.
- Full-width carry:
  - WORD_WIDTH=8, low=0, high=255, step=200, count 100, up → 0 with `bound_event`=1, wrap to low, not 44.
- Priority and out-of-range:
  - load=1, run=1, load_count=50 with high=9 → count 50, `bound_event`=0.
  - Next run up, step=1 → 2 (wrap mode).
- step=0, run=1 at count 7, up and down → count holds 7, `bound_event`=0.
